// File: rtl/proj_unidade_controle_if.sv
// Signal bundle between the game control unit and the chess-move datapath.
//   iniciar     start/restart request (level)
//   temJogada   one-cycle pulse: player placed a move
//   acertou     comparator result: registered move == expected square
//   fimT        game timer reached end of time
//   zeraT/zeraP/zeraR   synchronous clears for timer, score, move registers
//   registraR   move register load enable
//   novaJogada  request for a new target square
//   contaT      timer count-up enable
//   decresceT   timer count-down enable (bonus credit)
//   contaP      score increment enable
//   pronto      game over, score valid
//   db_estado   current state code for debug displays
// master: datapath side (drives status, receives controls)
// slave : control unit side (receives status, drives controls)
interface proj_unidade_controle_if;
  logic       iniciar;
  logic       temJogada;
  logic       acertou;
  logic       fimT;
  logic       zeraT;
  logic       zeraP;
  logic       zeraR;
  logic       registraR;
  logic       novaJogada;
  logic       contaT;
  logic       decresceT;
  logic       contaP;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output iniciar, temJogada, acertou, fimT,
    input  zeraT, zeraP, zeraR, registraR, novaJogada,
           contaT, decresceT, contaP, pronto, db_estado
  );

  modport slave (
    input  iniciar, temJogada, acertou, fimT,
    output zeraT, zeraP, zeraR, registraR, novaJogada,
           contaT, decresceT, contaP, pronto, db_estado
  );
endinterface

// File: rtl/proj_unidade_controle.sv
// Moore control unit sequencing the chess-move training datapath.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    proj_unidade_controle_if.slave (status in, controls out)
// Parameters:
//   BONUS    timer cycles credited (decresceT high) after each hit, 0 = none
//   BONUS_W  width of the bonus down-counter, 2**BONUS_W must exceed BONUS
//
// state    | meaning
// INICIAL  | idle after reset, waiting for iniciar
// PREPARA  | clear timer, score and move registers
// NOVA     | request a new target square
// ESPERA   | game time running, waiting for the player's move
// REGISTRA | load the player's move
// COMPARA  | evaluate comparator result
// ACERTO   | score the hit, load bonus counter
// BONUS    | credit bonus time, one cycle per count
// ERRO     | miss: clear move registers, back to waiting
// FIM      | game over, score valid
module proj_unidade_controle #(
  parameter int BONUS   = 1000,
  parameter int BONUS_W = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  proj_unidade_controle_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'h0,
    ST_PREPARA  = 4'h1,
    ST_NOVA     = 4'h2,
    ST_ESPERA   = 4'h3,
    ST_REGISTRA = 4'h4,
    ST_COMPARA  = 4'h5,
    ST_ACERTO   = 4'h6,
    ST_BONUS    = 4'h7,
    ST_ERRO     = 4'h8,
    ST_FIM      = 4'hF
  } state_t;

  localparam logic [BONUS_W-1:0] BONUS_LD = BONUS_W'(BONUS);
  localparam logic [BONUS_W-1:0] ONE      = BONUS_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [BONUS_W-1:0] bonus_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_INICIAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Loaded while scoring so BONUS starts with the full count; the state
  // leaves BONUS on the cycle the counter reads 1, giving exactly BONUS
  // cycles of decresceT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bonus_cnt <= '0;
    end else if (state == ST_ACERTO) begin
      bonus_cnt <= BONUS_LD;
    end else if (state == ST_BONUS && bonus_cnt != '0) begin
      bonus_cnt <= bonus_cnt - ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INICIAL:  state_nxt = bus.iniciar ? ST_PREPARA : ST_INICIAL;
      ST_PREPARA:  state_nxt = ST_NOVA;
      ST_NOVA:     state_nxt = ST_ESPERA;
      ST_ESPERA: begin
        if (bus.fimT)           state_nxt = ST_FIM;
        else if (bus.temJogada) state_nxt = ST_REGISTRA;
        else                    state_nxt = ST_ESPERA;
      end
      ST_REGISTRA: state_nxt = ST_COMPARA;
      ST_COMPARA: begin
        if (bus.fimT)         state_nxt = ST_FIM;
        else if (bus.acertou) state_nxt = ST_ACERTO;
        else                  state_nxt = ST_ERRO;
      end
      ST_ACERTO:   state_nxt = (BONUS > 0) ? ST_BONUS : ST_NOVA;
      // <= 1 also guards against a stray zero count ever stalling here
      ST_BONUS:    state_nxt = (bonus_cnt <= ONE) ? ST_NOVA : ST_BONUS;
      ST_ERRO:     state_nxt = bus.fimT ? ST_FIM : ST_ESPERA;
      ST_FIM:      state_nxt = bus.iniciar ? ST_PREPARA : ST_FIM;
      default:     state_nxt = ST_INICIAL;
    endcase
  end

  always_comb begin
    bus.zeraT      = 1'b0;
    bus.zeraP      = 1'b0;
    bus.zeraR      = 1'b0;
    bus.registraR  = 1'b0;
    bus.novaJogada = 1'b0;
    bus.contaT     = 1'b0;
    bus.decresceT  = 1'b0;
    bus.contaP     = 1'b0;
    bus.pronto     = 1'b0;
    case (state)
      ST_PREPARA: begin
        bus.zeraT = 1'b1;
        bus.zeraP = 1'b1;
        bus.zeraR = 1'b1;
      end
      ST_NOVA:     bus.novaJogada = 1'b1;
      ST_ESPERA:   bus.contaT = 1'b1;
      ST_REGISTRA: begin
        bus.contaT    = 1'b1;
        bus.registraR = 1'b1;
      end
      ST_COMPARA:  bus.contaT = 1'b1;
      ST_ACERTO:   bus.contaP = 1'b1;
      ST_BONUS:    bus.decresceT = 1'b1;
      ST_ERRO: begin
        bus.contaT = 1'b1;
        bus.zeraR  = 1'b1;
      end
      ST_FIM:      bus.pronto = 1'b1;
      default: ;
    endcase
  end

  assign bus.db_estado = state;

endmodule
